// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address and loads IF/ID.
// Define IF_PERF_CNT_EN to add the fetch/stall/flush event counters.
module if_stage #(
    parameter logic [31:0] RESET_PC    = 32'd0,
    parameter logic [31:0] BUBBLE_INST = 32'd0,
    parameter logic [31:0] PC_INC      = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_inst,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
`endif
    output logic        if_id_valid
);

    logic [31:0] pc_q;
    logic [31:0] pc_next;

    assign imem_pc = {pc_q[31:2], 2'b00};
    assign pc_next = pc_q + PC_INC;

    // Branch beats freeze: the redirect must land even while the pipe is stalled,
    // and the wrong-path word in IF/ID is replaced by a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            if_id_pc    <= 32'd0;
            if_id_inst  <= BUBBLE_INST;
            if_id_valid <= 1'b0;
        end else if (branch_taken) begin
            pc_q        <= {branch_addr[31:2], 2'b00};
            if_id_pc    <= 32'd0;
            if_id_inst  <= BUBBLE_INST;
            if_id_valid <= 1'b0;
        end else if (!freeze) begin
            pc_q        <= pc_next;
            if_id_pc    <= pc_next;
            if_id_inst  <= imem_inst;
            if_id_valid <= 1'b1;
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt <= 32'd0;
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else if (branch_taken) begin
            flush_cnt <= flush_cnt + 32'd1;
        end else if (freeze) begin
            stall_cnt <= stall_cnt + 32'd1;
        end else begin
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end
`endif

endmodule
